axi4_txn_sequencer: RTL

Upstream command stage for `axi4_top`. Buffers write/read burst commands from a host or test controller, issues them one at a time on `axi4_top`'s user interface, and waits for `wr_done`/`rd_done` before issuing the next. Checks returned read beats against the expected FIXED/INCR/WRAP pattern and keeps error and timeout statistics.

---
 rtl/axi4_seq_pkg.sv | 38 +++
 rtl/axi4_cmd_fifo.sv | 49 ++++
 rtl/axi4_txn_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/axi4_seq_pkg.sv
// Shared types for the AXI4 transaction sequencer: burst codes, FSM states,
// the queued command record and the read-beat expectation rule.
package axi4_seq_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_WR,
    ST_WAIT_WR,
    ST_ISSUE_RD,
    ST_WAIT_RD
  } state_t;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [31:0] data;
  } cmd_t;

  // Only beats with index <= len are ever compared, so for WRAP the
  // (i mod (len+1)) term reduces to i and no divider is needed.
  function automatic logic [31:0] beat_expect(input logic [31:0] start,
                                              input logic [1:0]  burst,
                                              input logic [8:0]  idx);
    return start + ((burst == BURST_FIXED) ? 32'd0 : {23'd0, idx});
  endfunction

endpackage

// File: rtl/axi4_cmd_fifo.sv
// Command FIFO: show-ahead head output, pointer-based full/empty, power-of-two depth.
module axi4_cmd_fifo
  import axi4_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  // Full blocks a push even when a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/axi4_txn_sequencer.sv
// Issues buffered AXI4 burst commands one at a time, checks returned read
// beats against the burst pattern, and tracks errors and WAIT timeouts.
module axi4_txn_sequencer
  import axi4_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [1:0]  cmd_burst,
  input  logic [31:0] cmd_data,
  output logic        wr_tx,
  output logic [31:0] wr_addr,
  output logic [7:0]  wr_len,
  output logic [2:0]  wr_size,
  output logic [1:0]  wr_burst,
  output logic [31:0] wr_data,
  input  logic        wr_done,
  output logic        rd_tx,
  output logic [31:0] rd_addr,
  output logic [7:0]  rd_len,
  output logic [2:0]  rd_size,
  output logic [1:0]  rd_burst,
  input  logic [31:0] rd_data,
  input  logic        rd_data_valid,
  input  logic        rd_done,
  output logic        busy,
  output logic        txn_done,
  output logic        mismatch,
  output logic [15:0] err_count
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  cmd_t        cmd_in;
  cmd_t        head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [7:0]  len_reg;
  logic [1:0]  burst_reg;
  logic [31:0] data_reg;
  logic [2:0]  size_reg;
  logic        wr_tx_reg;
  logic        rd_tx_reg;
  logic        txn_done_reg;
  logic        mismatch_reg;
  logic [15:0] err_count_reg;
  logic [8:0]  beat_cnt_reg;
  logic [WD_W-1:0] wdog_reg;

  logic        load;
  logic        issue_wr;
  logic        issue_rd;
  logic        retire;
  logic        err_any;
  logic        beat_bad;
  logic        timeout_hit;
  logic        in_wait;
  logic [31:0] exp_data;
  logic [9:0]  beats_seen;
  logic [9:0]  beats_needed;

  assign cmd_in.rw    = cmd_rw;
  assign cmd_in.addr  = cmd_addr;
  assign cmd_in.len   = cmd_len;
  assign cmd_in.burst = cmd_burst;
  assign cmd_in.data  = cmd_data;

  axi4_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (cmd_valid),
    .push_data (cmd_in),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_wait      = (state_reg == ST_WAIT_WR) || (state_reg == ST_WAIT_RD);
  assign timeout_hit  = (wdog_reg == WD_W'(TIMEOUT));
  assign exp_data     = beat_expect(data_reg, burst_reg, beat_cnt_reg);
  // A valid beat in the same cycle as rd_done still counts toward the total.
  assign beats_seen   = {1'b0, beat_cnt_reg} + {9'd0, rd_data_valid};
  assign beats_needed = {2'd0, len_reg} + 10'd1;

  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    load       = 1'b0;
    issue_wr   = 1'b0;
    issue_rd   = 1'b0;
    retire     = 1'b0;
    err_any    = 1'b0;
    beat_bad   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head.burst == BURST_RSVD) begin
            retire  = 1'b1;
            err_any = 1'b1;
          end else begin
            load       = 1'b1;
            state_next = head.rw ? ST_ISSUE_RD : ST_ISSUE_WR;
          end
        end
      end
      ST_ISSUE_WR: begin
        issue_wr   = 1'b1;
        state_next = ST_WAIT_WR;
      end
      ST_ISSUE_RD: begin
        issue_rd   = 1'b1;
        state_next = ST_WAIT_RD;
      end
      ST_WAIT_WR: begin
        if (wr_done) begin
          retire     = 1'b1;
          state_next = ST_IDLE;
        end else if (timeout_hit) begin
          retire     = 1'b1;
          err_any    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_RD: begin
        if (rd_data_valid) begin
          if (beat_cnt_reg > {1'b0, len_reg}) begin
            err_any = 1'b1;
          end else if (rd_data != exp_data) begin
            beat_bad = 1'b1;
            err_any  = 1'b1;
          end
        end
        if (rd_done) begin
          retire     = 1'b1;
          state_next = ST_IDLE;
          if (beats_seen < beats_needed) err_any = 1'b1;
        end else if (timeout_hit) begin
          retire     = 1'b1;
          err_any    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      len_reg       <= '0;
      burst_reg     <= '0;
      data_reg      <= '0;
      size_reg      <= '0;
      wr_tx_reg     <= 1'b0;
      rd_tx_reg     <= 1'b0;
      txn_done_reg  <= 1'b0;
      mismatch_reg  <= 1'b0;
      err_count_reg <= '0;
      beat_cnt_reg  <= '0;
      wdog_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      wr_tx_reg    <= issue_wr;
      rd_tx_reg    <= issue_rd;
      txn_done_reg <= retire;
      mismatch_reg <= beat_bad;
      if (load) begin
        addr_reg     <= head.addr;
        len_reg      <= head.len;
        burst_reg    <= head.burst;
        data_reg     <= head.data;
        size_reg     <= SIZE_4B;
        beat_cnt_reg <= '0;
      end else if (state_reg == ST_WAIT_RD && rd_data_valid && beat_cnt_reg != 9'h1FF) begin
        beat_cnt_reg <= beat_cnt_reg + 9'd1;
      end
      if (err_any && err_count_reg != 16'hFFFF) begin
        err_count_reg <= err_count_reg + 16'd1;
      end
      wdog_reg <= in_wait ? wdog_reg + WD_W'(1) : '0;
    end
  end

  assign cmd_ready = !fifo_full;
  assign busy      = !fifo_empty || (state_reg != ST_IDLE);
  assign wr_tx     = wr_tx_reg;
  assign rd_tx     = rd_tx_reg;
  assign wr_addr   = addr_reg;
  assign wr_len    = len_reg;
  assign wr_size   = size_reg;
  assign wr_burst  = burst_reg;
  assign wr_data   = data_reg;
  assign rd_addr   = addr_reg;
  assign rd_len    = len_reg;
  assign rd_size   = size_reg;
  assign rd_burst  = burst_reg;
  assign txn_done  = txn_done_reg;
  assign mismatch  = mismatch_reg;
  assign err_count = err_count_reg;

endmodule
